serial_pattern_detector: RTL
============================

# serial_pattern_detector

- Parametrised serial bit-pattern detector, successor to the fixed-pattern 4-state Moore sequence FSM.
- Samples one bit per qualified clock and raises a registered one-cycle `match` pulse when the last `PAT_LEN` accepted bits equal `PATTERN`.
- Adds over the fixed FSM: selectable overlap / non-overlap detection, input qualification, synchronous clear, a saturating match counter and an async active-low reset.
- Sits directly behind serial input samplers in the FPGA designs.

## Interface
- `PAT_LEN`, 3: pattern length in bits; legal range 2..32.
- `PATTERN`, 3'b011: `PAT_LEN`-bit target; `PATTERN[PAT_LEN-1]` is the first bit received, `PATTERN[0]` the last.
- `OVERLAP`, 1: 1 = overlapping matches allowed; 0 = history restarts after each match.
- `CNT_W`, 8: match counter width; legal range 1..32.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `clr` in 1: synchronous clear; priority over `in_valid`.
- `in_valid` in 1: qualifies `in` for this cycle.
- `in` in 1: serial data bit.
- `match` out 1: registered one-cycle match pulse.
- `fill` out clog2(PAT_LEN+1): number of valid history bits, 0..`PAT_LEN`.
- `count` out CNT_W: saturating count of matches.

## Operation
- **State held:**
  - history shift register `hist[PAT_LEN-1:0]`
  - fill counter
  - `match` register
  - `count` register
- **Reset (`rst_n` low, any time, mid-pattern included):** `hist`=0, `fill`=0, `match`=0, `count`=0 immediately. Partial sequences are discarded.
- **`clr` high at an edge:** same values as reset, loaded synchronously. The bit on `in` that cycle is discarded even if `in_valid`=1.
- **`in_valid`=0 (and `clr`=0):** `hist`, `fill` and `count` hold; `match` loads 0.
- **`in_valid`=1 (and `clr`=0):**
  - `hist_n = {hist[PAT_LEN-2:0], in}`.
  - `fill_n = min(fill+1, PAT_LEN)`.
  - `hit = (fill_n == PAT_LEN) && (hist_n == PATTERN)`.
  - `hist` loads `hist_n`; `match` loads `hit`.
  - `fill` loads `fill_n`, except when `hit` and `OVERLAP`=0, in which case `fill` loads 0.
  - On `hit`, `count` increments, holding at 2^CNT_W−1 once reached (no wrap).
- **Effective states:** fill 0..`PAT_LEN−1` (priming) and `PAT_LEN` (armed). A match requires the armed state, so no false match is possible from reset-zero history.

## Timing
- Latency: `match` is high for exactly the cycle following the rising edge that sampled the final pattern bit.
- `count` updates at that same edge.
- Back-to-back matches:
  - with `OVERLAP`=1, `match` may stay high on consecutive cycles when every `in_valid` bit completes a match (e.g. all-ones pattern, all-ones stream);
  - with `OVERLAP`=0, the minimum spacing is `PAT_LEN` accepted bits.
- No combinational path from any input to any output.
- `in_valid` gaps of any length are transparent to detection.

## Configuration
- Macro: `SERIAL_PATTERN_DETECTOR_COUNT_EN`.
- **Defined:** the `count` register and saturation logic are built as described above.
- **Not defined:** no counter register is built and `count` is tied to 0. `match` and `fill` behaviour are unchanged.

## Test plan
- **Defaults (`PATTERN` 011), counter enabled:** `in_valid`=1, stream 0,1,1 → `match` low after edges 1–2, high for one cycle after edge 3, low after edge 4; `count`=1.
- **`PAT_LEN`=4, `PATTERN`=4'b1010, stream 1,0,1,0,1,0:**
  - `OVERLAP`=1 → `match` pulses after bits 4 and 6, `count`=2.
  - `OVERLAP`=0 → pulse after bit 4 only, `count`=1, `fill`=2 at end.
- **Gaps:** defaults, stream 0,1,1 with `in_valid`=0 for 5 cycles between each bit → exactly one `match` pulse, after the edge sampling the last 1; `match` stays 0 during the gaps.
- **Reset / clear mid-pattern:** after 0,1 accepted, pulse `rst_n` low between edges, then feed 1 → no `match`, `fill`=1. Repeat using `clr`=1 together with `in_valid`=1, `in`=1 → that bit is discarded and `fill`=0.
- **Saturation:** `CNT_W`=2, defaults, 5 × (0,1,1) → 5 `match` pulses; `count` reads 1,2,3,3,3.
- **Macro off:** same stimulus as the first scenario → `match` identical, `count`=0 throughout.

Source files
------------

// File: rtl/serial_pattern_detector_if.sv
// Serial bit stream in, match/fill/count status out, for serial_pattern_detector.
// The master drives the qualified bit stream; the slave (the detector) reports status.
interface serial_pattern_detector_if #(
  parameter int PAT_LEN = 3,
  parameter int CNT_W   = 8
);
  localparam int FILL_W = $clog2(PAT_LEN + 1);

  logic              clr;
  logic              in_valid;
  logic              in;
  logic              match;
  logic [FILL_W-1:0] fill;
  logic [CNT_W-1:0]  count;

  modport master (
    output clr, in_valid, in,
    input  match, fill, count
  );

  modport slave (
    input  clr, in_valid, in,
    output match, fill, count
  );
endinterface

// File: rtl/serial_pattern_detector.sv
// Parametrised serial pattern detector with overlap control, clear and a match counter.
// The saturating counter is built only when SERIAL_PATTERN_DETECTOR_COUNT_EN is defined.
module serial_pattern_detector #(
  parameter int               PAT_LEN = 3,
  parameter logic [PAT_LEN-1:0] PATTERN = 3'b011,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  serial_pattern_detector_if.slave bus
);
  localparam int FILL_W = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

  logic [PAT_LEN-1:0] hist_reg, hist_next;
  logic [FILL_W-1:0]  fill_reg, fill_next;
  logic               match_reg, match_next;
  logic [PAT_LEN-1:0] shifted;
  logic [FILL_W-1:0]  fill_inc;
  logic               hit;

  // Match needs a full (armed) history, so the zeroed reset history cannot fire.
  always_comb begin
    shifted  = {hist_reg[PAT_LEN-2:0], bus.in};
    fill_inc = (fill_reg == FILL_FULL) ? fill_reg : fill_reg + 1'b1;
    hit      = bus.in_valid && !bus.clr && (fill_inc == FILL_FULL) && (shifted == PATTERN);

    hist_next  = hist_reg;
    fill_next  = fill_reg;
    match_next = 1'b0;

    if (bus.clr) begin
      hist_next = '0;
      fill_next = '0;
    end else if (bus.in_valid) begin
      hist_next  = shifted;
      match_next = hit;
      fill_next  = (hit && !OVERLAP) ? '0 : fill_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_reg  <= '0;
      fill_reg  <= '0;
      match_reg <= 1'b0;
    end else begin
      hist_reg  <= hist_next;
      fill_reg  <= fill_next;
      match_reg <= match_next;
    end
  end

  assign bus.match = match_reg;
  assign bus.fill  = fill_reg;

`ifdef SERIAL_PATTERN_DETECTOR_COUNT_EN
  logic [CNT_W-1:0] count_reg, count_next;

  always_comb begin
    count_next = count_reg;
    if (bus.clr) begin
      count_next = '0;
    end else if (hit && (count_reg != {CNT_W{1'b1}})) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign bus.count = count_reg;
`else
  assign bus.count = '0;
`endif
endmodule
